writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the 5-stage MIPS core. It sits directly downstream of the memory stage and registers everything that stage produces.
- Drives the byte-enabled register-file write port and the debug writeback trace.
- Owns the architectural HI/LO registers: mult/multu/div/divu/mthi/mtlo write them, and mfhi/mflo read them into the GPR write data.

Parameters:
- RESET_PC, 32'hbfc00000, value of wb_pc and debug_wb_pc after reset.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  MEM stage holds a live instruction
- mem_out_op  in  3  bit0 = GPR write; bits 2:1 reserved, ignored
- mem_dest  in  5  destination GPR number
- mem_value  in  32  load data or ALU result from MEM
- mem_pc  in  32  PC in MEM
- mem_inst  in  32  instruction word in MEM
- load_wen  in  4  byte-lane enables from MEM load alignment
- mul_div_result  in  64  divider {rem,quot}, valid when MEM holds div/divu
- mem_mul  in  1  MEM holds mult/multu
- mul_result  in  64  multiplier product {hi,lo}, valid in the cycle the mult is in WB
- wb_rf_wen  out  4  GPR byte write enables
- wb_rf_waddr  out  5  GPR write address
- wb_rf_wdata  out  32  GPR write data
- wb_dest  out  5  dest number for hazard detection; 0 when no write
- hi_value  out  32  current HI, for bypass
- lo_value  out  32  current LO, for bypass
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace, equals wb_rf_wen
- debug_wb_rf_wnum  out  5  trace, equals wb_rf_waddr
- debug_wb_rf_wdata  out  32  trace, equals wb_rf_wdata

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (resetn).
- Pipeline register:
  - On posedge clk with resetn=1, capture mem_valid, out_op, dest, value, pc, inst, load_wen, mul_div_result and mem_mul into wb_* registers.
  - All outputs are combinational from these registers and HI/LO.
  - Latency: one cycle from MEM to the rf write.
- Reset values:
  - wb_valid=0, all wb_* data regs 0, wb_pc=RESET_PC, HI=LO=0.
  - Therefore wb_rf_wen=0, wb_dest=0, debug_wb_pc=RESET_PC, hi_value=lo_value=0.
  - Reset asserted while a mult/div is in WB cancels its HI/LO write.
- Decode from wb_inst:
  - is_load: inst[31:29]==3'b100.
  - SPECIAL (opcode 0) functs: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011.
- GPR write:
  - wen_raw = wb_valid & out_op[0] & (dest!=0).
  - wb_rf_wen = !wen_raw ? 0 : is_load ? wb_load_wen : 4'hf.
  - A load with load_wen=0 writes nothing.
- Write data (priority order): mfhi -> HI; mflo -> LO; otherwise wb_value. For lwl/lwr, the regfile merges lanes per wen; this block does not merge.
- wb_dest = (wb_rf_wen!=0) ? wb_rf_waddr : 0.
- HI/LO update, end of WB cycle, only when wb_valid:
  - div/divu: HI<=wb_mul_div_result[63:32], LO<=[31:0].
  - mult/multu (wb_mul=1): HI<=mul_result[63:32], LO<=mul_result[31:0].
  - mthi: HI<=wb_value. mtlo: LO<=wb_value.
  - Mutually exclusive by decode; if violated, priority is div > mul > mthi/mtlo.
- Back-to-back hazards:
  - mthi then mfhi in consecutive WB cycles: mfhi returns the new value, because HI was written at the edge between them.
  - mult followed by mflo behaves the same way.
  - Same-cycle HI/LO bypass is performed upstream using hi_value/lo_value; this block provides no extra bypass.
- Bubbles: mem_valid=0 produces a bubble. With wb_valid=0, HI/LO are unchanged and wb_rf_wen=0, but debug_wb_pc still shows the captured pc.

Decomposition:
- Shared package (mips_defs): opcode/funct constants listed above, RESET_PC, out_op bit index for GPR write.
- One sub-module, hilo_reg:
  - Ports: clk, resetn, hi_we, lo_we, hi_d, lo_d, hi_q, lo_q.
  - Contains HI/LO storage and reset.
- Priority mux and decode stay in writeback_stage.

Test Plan:
- Reset: hold resetn=0 for 3 cycles while driving a valid addu -> wb_rf_wen=0, debug_wb_pc=32'hbfc00000, hi_value=lo_value=0; release, then addu $3 (value 0x12345678) -> next cycle wb_rf_wen=4'hf, waddr=3, wdata=0x12345678.
- lwr with load_wen=4'b0011, value 0x0000abcd, dest 5 -> wb_rf_wen=4'b0011, wdata=0x0000abcd; same load with dest 0 -> wen=0, wb_dest=0.
- mult with mul_result=64'h00000001_fffffffe, then mfhi $2, then mflo $4 -> wdata 0x00000001, then 0xfffffffe.
- div with mul_div_result=64'h00000003_00000007 -> hi_value=3, lo_value=7 the cycle after; mthi (value 0xdeadbeef) immediately followed by mfhi -> wdata 0xdeadbeef.
- Bubble: div with mem_valid=0 -> HI/LO unchanged, wb_rf_wen=0.
- resetn=0 in the cycle a mult is in WB -> HI=LO=0 afterwards.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS core definitions: reset vector, SPECIAL funct codes and
// out_op bit positions used by the writeback stage.
package mips_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // Position of the GPR-write flag inside out_op.
    localparam int unsigned OUT_OP_GPR_WEN = 0;

    // Loads all live in the 100xxx opcode group.
    function automatic logic inst_is_load(input logic [31:0] inst);
        return inst[31:29] == 3'b100;
    endfunction

endpackage

// File: rtl/writeback_stage_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_d,
    input  logic [31:0] lo_d,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    // HI/LO storage; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM stage outputs, drives the GPR write
// port and debug trace, and owns the HI/LO registers.
module writeback_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [2:0]  mem_out_op,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_value,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_inst,
    input  logic [3:0]  load_wen,
    input  logic [63:0] mul_div_result,
    input  logic        mem_mul,
    input  logic [63:0] mul_result,
    output logic [3:0]  wb_rf_wen,
    output logic [4:0]  wb_rf_waddr,
    output logic [31:0] wb_rf_wdata,
    output logic [4:0]  wb_dest,
    output logic [31:0] hi_value,
    output logic [31:0] lo_value,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic        wb_valid;
    logic        wb_gpr_op;
    logic [4:0]  wb_dest_q;
    logic [31:0] wb_value;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic [3:0]  wb_load_wen;
    logic [63:0] wb_mul_div_result;
    logic        wb_mul;

    // MEM -> WB pipeline register; only the GPR-write bit of out_op is kept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid          <= 1'b0;
            wb_gpr_op         <= 1'b0;
            wb_dest_q         <= '0;
            wb_value          <= '0;
            wb_pc             <= RESET_PC;
            wb_inst           <= '0;
            wb_load_wen       <= '0;
            wb_mul_div_result <= '0;
            wb_mul            <= 1'b0;
        end else begin
            wb_valid          <= mem_valid;
            wb_gpr_op         <= mem_out_op[OUT_OP_GPR_WEN];
            wb_dest_q         <= mem_dest;
            wb_value          <= mem_value;
            wb_pc             <= mem_pc;
            wb_inst           <= mem_inst;
            wb_load_wen       <= load_wen;
            wb_mul_div_result <= mul_div_result;
            wb_mul            <= mem_mul;
        end
    end

    // Reserved out_op bits and the register-number fields of the
    // instruction word carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_out_op[2:1], wb_inst[25:6]};

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_special;
    logic       is_load;
    logic       is_mfhi;
    logic       is_mflo;
    logic       is_mthi;
    logic       is_mtlo;
    logic       is_div;

    assign opcode     = wb_inst[31:26];
    assign funct      = wb_inst[5:0];
    assign is_special = (opcode == OP_SPECIAL);
    assign is_load    = inst_is_load(wb_inst);
    assign is_mfhi    = is_special && (funct == FUNCT_MFHI);
    assign is_mflo    = is_special && (funct == FUNCT_MFLO);
    assign is_mthi    = is_special && (funct == FUNCT_MTHI);
    assign is_mtlo    = is_special && (funct == FUNCT_MTLO);
    assign is_div     = is_special && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));

    logic        wen_raw;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    assign wen_raw = wb_valid && wb_gpr_op && (wb_dest_q != 5'd0);

    // GPR write enables and data; mfhi/mflo take priority over the MEM value.
    always_comb begin
        wb_rf_wen = 4'h0;
        if (wen_raw) wb_rf_wen = is_load ? wb_load_wen : 4'hf;
        if (is_mfhi)      wb_rf_wdata = hi_q;
        else if (is_mflo) wb_rf_wdata = lo_q;
        else              wb_rf_wdata = wb_value;
    end

    assign wb_rf_waddr = wb_dest_q;
    assign wb_dest     = (wb_rf_wen != 4'h0) ? wb_dest_q : 5'd0;

    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    // HI/LO source select: div beats mult beats mthi/mtlo.
    always_comb begin
        hi_we = wb_valid && (is_div || wb_mul || is_mthi);
        lo_we = wb_valid && (is_div || wb_mul || is_mtlo);
        if (is_div) begin
            hi_d = wb_mul_div_result[63:32];
            lo_d = wb_mul_div_result[31:0];
        end else if (wb_mul) begin
            hi_d = mul_result[63:32];
            lo_d = mul_result[31:0];
        end else begin
            hi_d = wb_value;
            lo_d = wb_value;
        end
    end

    hilo_reg u_hilo (
        .clk    (clk),
        .resetn (resetn),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .hi_d   (hi_d),
        .lo_d   (lo_d),
        .hi_q   (hi_q),
        .lo_q   (lo_q)
    );

    assign hi_value          = hi_q;
    assign lo_value          = lo_q;
    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_wen   = wb_rf_wen;
    assign debug_wb_rf_wnum  = wb_rf_waddr;
    assign debug_wb_rf_wdata = wb_rf_wdata;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage.
module tb_writeback_stage;

    localparam logic [31:0] ADDU  = 32'h00000021;
    localparam logic [31:0] MULT  = 32'h00000018;
    localparam logic [31:0] DIV   = 32'h0000001a;
    localparam logic [31:0] DIVU  = 32'h0000001b;
    localparam logic [31:0] MFHI  = 32'h00000010;
    localparam logic [31:0] MTHI  = 32'h00000011;
    localparam logic [31:0] MFLO  = 32'h00000012;
    localparam logic [31:0] MTLO  = 32'h00000013;
    localparam logic [31:0] LW    = 32'h8c000000;
    localparam logic [31:0] LWR   = 32'h98000000;
    localparam logic [63:0] JUNK  = 64'h55555555_aaaaaaaa;
    localparam logic [63:0] Z64   = 64'h0;
    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [2:0]  mem_out_op;
    logic [4:0]  mem_dest;
    logic [31:0] mem_value;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic [3:0]  load_wen;
    logic [63:0] mul_div_result;
    logic        mem_mul;
    logic [63:0] mul_result;
    logic [3:0]  wb_rf_wen;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic [4:0]  wb_dest;
    logic [31:0] hi_value;
    logic [31:0] lo_value;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    writeback_stage #(.RESET_PC(32'hbfc00000)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_valid         (mem_valid),
        .mem_out_op        (mem_out_op),
        .mem_dest          (mem_dest),
        .mem_value         (mem_value),
        .mem_pc            (mem_pc),
        .mem_inst          (mem_inst),
        .load_wen          (load_wen),
        .mul_div_result    (mul_div_result),
        .mem_mul           (mem_mul),
        .mul_result        (mul_result),
        .wb_rf_wen         (wb_rf_wen),
        .wb_rf_waddr       (wb_rf_waddr),
        .wb_rf_wdata       (wb_rf_wdata),
        .wb_dest           (wb_dest),
        .hi_value          (hi_value),
        .lo_value          (lo_value),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    // One row: MEM inputs, the mul_result shown while this row sits in WB,
    // and the outputs expected while it sits in WB.
    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic [31:0] value;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  lwen;
        logic [63:0] mdr;
        logic        mul;
        logic [63:0] mres;
        logic [3:0]  e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [4:0]  e_dest;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [4:0] dst,
                           input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] pc);
        chk({tag, " wen"},   {28'h0, wb_rf_wen}, {28'h0, wen});
        chk({tag, " waddr"}, {27'h0, wb_rf_waddr}, {27'h0, waddr});
        chk({tag, " wdata"}, wb_rf_wdata, wdata);
        chk({tag, " dest"},  {27'h0, wb_dest}, {27'h0, dst});
        chk({tag, " hi"},    hi_value, hi);
        chk({tag, " lo"},    lo_value, lo);
        chk({tag, " dbg_pc"}, debug_wb_pc, pc);
        chk({tag, " dbg_wen"},   {28'h0, debug_wb_rf_wen}, {28'h0, wen});
        chk({tag, " dbg_wnum"},  {27'h0, debug_wb_rf_wnum}, {27'h0, waddr});
        chk({tag, " dbg_wdata"}, debug_wb_rf_wdata, wdata);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] d,
                         input logic [31:0] val, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [3:0] lw, input logic [63:0] mdr, input logic mul);
        mem_valid      = v;
        mem_out_op     = op;
        mem_dest       = d;
        mem_value      = val;
        mem_pc         = pc;
        mem_inst       = inst;
        load_wen       = lw;
        mul_div_result = mdr;
        mem_mul        = mul;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 3'd1, 5'd3,  32'h12345678, 32'h100, ADDU, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd3,  32'h12345678, 5'd3,  32'h0, 32'h0};
        tbl[1]  = '{1'b1, 3'd1, 5'd5,  32'h0000abcd, 32'h104, LWR, 4'b0011, Z64, 1'b0, JUNK,
                    4'b0011, 5'd5, 32'h0000abcd, 5'd5, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 3'd1, 5'd0,  32'h0000abcd, 32'h108, LWR, 4'b0011, Z64, 1'b0, JUNK,
                    4'h0, 5'd0,  32'h0000abcd, 5'd0,  32'h0, 32'h0};
        tbl[3]  = '{1'b1, 3'd1, 5'd6,  32'h11112222, 32'h10c, LW, 4'h0, Z64, 1'b0, JUNK,
                    4'h0, 5'd6,  32'h11112222, 5'd0,  32'h0, 32'h0};
        tbl[4]  = '{1'b1, 3'd0, 5'd0,  32'h0, 32'h110, MULT, 4'h0, Z64, 1'b1, 64'h00000001_fffffffe,
                    4'h0, 5'd0,  32'h0, 5'd0,  32'h0, 32'h0};
        tbl[5]  = '{1'b1, 3'd1, 5'd2,  32'h0, 32'h114, MFHI, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd2,  32'h00000001, 5'd2, 32'h00000001, 32'hfffffffe};
        tbl[6]  = '{1'b1, 3'd1, 5'd4,  32'h0, 32'h118, MFLO, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd4,  32'hfffffffe, 5'd4, 32'h00000001, 32'hfffffffe};
        tbl[7]  = '{1'b1, 3'd0, 5'd0,  32'h0, 32'h11c, DIV, 4'h0, 64'h00000003_00000007, 1'b0, JUNK,
                    4'h0, 5'd0,  32'h0, 5'd0,  32'h00000001, 32'hfffffffe};
        tbl[8]  = '{1'b1, 3'd1, 5'd7,  32'h00000011, 32'h120, ADDU, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd7,  32'h00000011, 5'd7, 32'h3, 32'h7};
        tbl[9]  = '{1'b1, 3'd0, 5'd0,  32'hdeadbeef, 32'h124, MTHI, 4'h0, Z64, 1'b0, JUNK,
                    4'h0, 5'd0,  32'hdeadbeef, 5'd0, 32'h3, 32'h7};
        tbl[10] = '{1'b1, 3'd1, 5'd2,  32'h0, 32'h128, MFHI, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd2,  32'hdeadbeef, 5'd2, 32'hdeadbeef, 32'h7};
        tbl[11] = '{1'b1, 3'd0, 5'd0,  32'h0badf00d, 32'h12c, MTLO, 4'h0, Z64, 1'b0, JUNK,
                    4'h0, 5'd0,  32'h0badf00d, 5'd0, 32'hdeadbeef, 32'h7};
        tbl[12] = '{1'b1, 3'd1, 5'd9,  32'h0, 32'h130, MFLO, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd9,  32'h0badf00d, 5'd9, 32'hdeadbeef, 32'h0badf00d};
        tbl[13] = '{1'b0, 3'd1, 5'd8,  32'h00000077, 32'h134, DIV, 4'h0, 64'h99999999_88888888, 1'b0, JUNK,
                    4'h0, 5'd8,  32'h00000077, 5'd0, 32'hdeadbeef, 32'h0badf00d};
        tbl[14] = '{1'b0, 3'd0, 5'd0,  32'h0, 32'h138, MULT, 4'h0, Z64, 1'b1, 64'h12345678_9abcdef0,
                    4'h0, 5'd0,  32'h0, 5'd0,  32'hdeadbeef, 32'h0badf00d};
        tbl[15] = '{1'b1, 3'd0, 5'd0,  32'h0, 32'h13c, DIVU, 4'h0, 64'h00000004_00000005, 1'b1, 64'hffffffff_ffffffff,
                    4'h0, 5'd0,  32'h0, 5'd0,  32'hdeadbeef, 32'h0badf00d};
        tbl[16] = '{1'b1, 3'd7, 5'd31, 32'hcafef00d, 32'h140, ADDU, 4'h0, Z64, 1'b0, JUNK,
                    4'hf, 5'd31, 32'hcafef00d, 5'd31, 32'h4, 32'h5};
        tbl[17] = '{1'b1, 3'd0, 5'd0,  32'h0, 32'h144, MULT, 4'h0, Z64, 1'b1, 64'h0000000a_0000000b,
                    4'h0, 5'd0,  32'h0, 5'd0,  32'h4, 32'h5};

        // Reset held for three cycles while a live addu is presented.
        resetn     = 1'b0;
        mul_result = JUNK;
        drive(1'b1, 3'd1, 5'd3, 32'h12345678, 32'h200, ADDU, 4'h0, Z64, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 4'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, RST_PC);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].valid, tbl[i].op, tbl[i].dest, tbl[i].value, tbl[i].pc,
                  tbl[i].inst, tbl[i].lwen, tbl[i].mdr, tbl[i].mul);
            @(posedge clk);
            #1;
            mul_result = tbl[i].mres;
            chk_all($sformatf("row%0d", i), tbl[i].e_wen, tbl[i].e_waddr, tbl[i].e_wdata,
                    tbl[i].e_dest, tbl[i].e_hi, tbl[i].e_lo, tbl[i].pc);
        end

        // Row 17's mult is in WB now: reset in this cycle must cancel its HI/LO write.
        resetn = 1'b0;
        drive(1'b0, 3'd0, 5'd0, 32'h0, 32'h300, ADDU, 4'h0, Z64, 1'b0);
        @(posedge clk);
        #1;
        mul_result = JUNK;
        chk_all("rst_mult", 4'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, RST_PC);

        // After release, mfhi reads the cleared HI.
        resetn = 1'b1;
        drive(1'b1, 3'd1, 5'd12, 32'h0, 32'h304, MFHI, 4'h0, Z64, 1'b0);
        @(posedge clk);
        #1;
        chk_all("post_rst_mfhi", 4'hf, 5'd12, 32'h0, 5'd12, 32'h0, 32'h0, 32'h304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
